// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the two-input gate block: walks {a,b} through 00..11, checks gate_vec.
// Optional macro GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching combination.
module gate_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] gate_vec,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_bist_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;

  logic       mismatch;
  logic       stop_run;
  logic [2:0] err_next;
  logic [3:0] mask_next;

  // Golden outputs {not, buf, and, or, nand, nor, xor, xnor}; not/buf follow a.
  function automatic logic [7:0] golden(logic [1:0] idx);
    case (idx)
      2'd0:    return 8'b1000_1101;
      2'd1:    return 8'b1001_1010;
      2'd2:    return 8'b0101_1010;
      default: return 8'b0111_0001;
    endcase
  endfunction

  assign mismatch  = (gate_vec != golden(idx_q));
  assign err_next  = mismatch ? err_q + 3'd1 : err_q;
  assign mask_next = mismatch ? (mask_q | (4'd1 << idx_q)) : mask_q;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  assign stop_run = mismatch;
`else
  assign stop_run = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = 2'd0;
          cnt_d   = SettleLoad;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q == 4'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        err_d  = err_next;
        mask_d = mask_next;
        if (idx_q == 2'd3 || stop_run) begin
          state_d = StDone;
          pass_d  = (err_next == 3'd0);
        end else begin
          state_d = StDrive;
          idx_d   = idx_q + 2'd1;
          cnt_d   = SettleLoad;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= 2'd0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  // idx_q doubles as the registered gate drive, so it holds 11 after a full run.
  assign a_out     = idx_q[1];
  assign b_out     = idx_q[0];
  assign busy      = (state_q == StDrive) || (state_q == StSample);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (S=2, S=1) against a cycle-time reference model,
// with a fault-injectable gate model, directed scenarios and a randomized phase.
module tb_gate_bist_ctrl;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      start;
  logic [1:0]      a, b, busy, done, pass;
  logic [1:0][2:0] err;
  logic [1:0][3:0] fmask;
  logic [1:0][7:0] gvec, stuck0, stuck1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int s_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [7:0] ideal(logic ia, logic ib);
    return {~ia, ia, ia & ib, ia | ib, ~(ia & ib), ~(ia | ib), ia ^ ib, ~(ia ^ ib)};
  endfunction

  function automatic logic [7:0] faulty(logic ia, logic ib, logic [7:0] s0, logic [7:0] s1);
    return (ideal(ia, ib) & ~s0) | s1;
  endfunction

  // Which combinations a given fault makes wrong.
  function automatic logic [3:0] fails_of(logic [7:0] s0, logic [7:0] s1);
    logic [3:0] f;
    logic [1:0] c;
    f = '0;
    for (int j = 0; j < 4; j++) begin
      c = 2'(j);
      f[j] = (faulty(c[1], c[0], s0, s1) != ideal(c[1], c[0]));
    end
    return f;
  endfunction

  function automatic int len_of(logic [3:0] f);
    if (STOP && f != 4'd0) begin
      for (int j = 0; j < 4; j++) if (f[j]) return j + 1;
    end
    return 4;
  endfunction

  function automatic logic [3:0] len_mask(int l);
    return 4'((1 << l) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    assign gvec[g] = faulty(a[g], b[g], stuck0[g], stuck1[g]);
  end

  gate_bist_ctrl #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .gate_vec(gvec[0]),
    .a_out(a[0]), .b_out(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .fail_mask(fmask[0])
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .gate_vec(gvec[1]),
    .a_out(a[1]), .b_out(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .fail_mask(fmask[1])
  );

  // Model: t = cycles since the accepting edge; the run lasts len*(S+1) cycles plus DONE.
  bit         m_run [2];
  int         m_t   [2];
  int         m_len [2];
  logic [3:0] m_fails [2];
  logic [1:0] h_ab  [2];
  logic [3:0] h_mask[2];
  logic       h_pass[2];

  for (genvar g = 0; g < 2; g++) begin : g_model
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_run[g]   <= 1'b0;
        m_t[g]     <= 0;
        m_len[g]   <= 4;
        m_fails[g] <= '0;
        h_ab[g]    <= '0;
        h_mask[g]  <= '0;
        h_pass[g]  <= 1'b0;
      end else if (!m_run[g]) begin
        if (start[g]) begin
          m_run[g]   <= 1'b1;
          m_t[g]     <= 0;
          m_fails[g] <= fails_of(stuck0[g], stuck1[g]);
          m_len[g]   <= len_of(fails_of(stuck0[g], stuck1[g]));
        end
      end else if (m_t[g] == m_len[g] * (s_of(g) + 1)) begin
        m_run[g]  <= 1'b0;
        h_ab[g]   <= 2'(m_len[g] - 1);
        h_mask[g] <= m_fails[g] & len_mask(m_len[g]);
        h_pass[g] <= ((m_fails[g] & len_mask(m_len[g])) == 4'd0);
      end else begin
        m_t[g] <= m_t[g] + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int s1, d, t, e_ab, e_busy, e_done, e_pass;
    logic [3:0] chk, e_mask;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        s1 = s_of(i) + 1;
        d  = m_len[i] * s1;
        t  = m_t[i];
        if (m_run[i] && t < d) begin
          chk = '0;
          for (int j = 0; j < 4; j++) if (j * s1 + s_of(i) < t) chk[j] = 1'b1;
          e_ab = t / s1; e_mask = m_fails[i] & chk; e_pass = 0; e_busy = 1; e_done = 0;
        end else if (m_run[i]) begin
          e_ab = m_len[i] - 1; e_mask = m_fails[i] & len_mask(m_len[i]);
          e_pass = (e_mask == 4'd0) ? 1 : 0; e_busy = 0; e_done = 1;
        end else begin
          e_ab = h_ab[i]; e_mask = h_mask[i]; e_pass = h_pass[i]; e_busy = 0; e_done = 0;
        end
        check($sformatf("i%0d ab", i), {30'd0, a[i], b[i]}, e_ab);
        check($sformatf("i%0d busy", i), busy[i], e_busy);
        check($sformatf("i%0d done", i), done[i], e_done);
        check($sformatf("i%0d pass", i), pass[i], e_pass);
        check($sformatf("i%0d err_count", i), err[i], $countones(e_mask));
        check($sformatf("i%0d fail_mask", i), fmask[i], e_mask);
      end
    end
  end

  task automatic directed(input int i, input logic [7:0] s0, input int exp_cyc,
                          input int exp_err, input int exp_mask, input int exp_pass);
    int n;
    @(negedge clk);
    stuck0[i] = s0;
    stuck1[i] = 8'd0;
    start[i]  = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    n = 0;
    while (done[i] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("i%0d done cycle", i), n, exp_cyc);
    check($sformatf("i%0d final err", i), err[i], exp_err);
    check($sformatf("i%0d final mask", i), fmask[i], exp_mask);
    check($sformatf("i%0d final pass", i), pass[i], exp_pass);
    @(negedge clk);
    stuck0[i] = 8'd0;
  endtask

  initial begin
    int dones;
    rst_n  = 1'b0;
    start  = '0;
    stuck0 = '0;
    stuck1 = '0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset ab", {a, b}, 0);
    check("reset err/mask", {err, fmask}, 0);

    directed(0, 8'h00, 12, 0, 4'b0000, 1);
    directed(0, 8'h01, STOP ? 3 : 12, STOP ? 1 : 2, STOP ? 4'b0001 : 4'b1001, 0);
    directed(1, 8'h00, 8, 0, 4'b0000, 1);

    // start held high through one run; prior fail results must clear on accept
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    check("held start cleared err", err[0], 0);
    check("held start cleared mask", fmask[0], 0);
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      if (n == 11) start[0] = 1'b0;
      if (done[0] === 1'b1) dones++;
      @(negedge clk);
    end
    check("held start done count", dones, 1);

    // reset in cycle 5 of a run on both instances
    start = 2'b11;
    @(negedge clk);
    start = 2'b00;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ab", {a, b}, 0);
    check("async reset busy/done", {busy, done}, 0);
    check("async reset pass", pass, 0);
    check("async reset err/mask", {err, fmask}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 2'b00) dones++;
    end
    check("no done after reset", dones, 0);
    directed(0, 8'h00, 12, 0, 4'b0000, 1);

    // randomized runs with random stuck-at faults, changed only while idle
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!m_run[i]) begin
          case ($urandom_range(0, 3))
            0: begin stuck0[i] = 8'd0; stuck1[i] = 8'd0; end
            1: begin stuck0[i] = 8'd1 << $urandom_range(0, 7); stuck1[i] = 8'd0; end
            2: begin stuck0[i] = 8'd0; stuck1[i] = 8'd1 << $urandom_range(0, 7); end
            default: begin
              stuck0[i] = 8'($urandom) & 8'($urandom);
              stuck1[i] = 8'($urandom) & 8'($urandom) & ~stuck0[i];
            end
          endcase
        end
        start[i] = ($urandom_range(0, 5) == 0);
      end
    end
    start = '0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
